// File: rtl/ucode_sequencer_pkg.sv
// ucode_sequencer_pkg: sequencer FSM state encoding, address/count width defaults and minimum uop count
package ucode_sequencer_pkg;
  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} seq_state_e;
  localparam int ADDR_W_DEF = 8;
  localparam int UOP_CNT_W_DEF = 3;
  localparam int UOP_CNT_MIN = 1;
endpackage

// File: rtl/ucode_addr_ctr.sv
// ucode_addr_ctr: loadable wrapping ROM address incrementer paired with a uop index counter (load/inc/hold)
module ucode_addr_ctr
  import ucode_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int UOP_CNT_W = UOP_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 inc,
  input  logic [ADDR_W-1:0]    load_addr,
  output logic [ADDR_W-1:0]    addr,
  output logic [UOP_CNT_W-1:0] idx
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      idx  <= '0;
    end else if (load) begin
      addr <= load_addr;
      idx  <= '0;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
      idx  <= idx + UOP_CNT_W'(1);
    end
  end
endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: steps control-ROM addresses for each uop of a decoded instruction and acks on the last; UCODE_SEQ_PERF_EN adds saturating uop/stall counters
module ucode_sequencer
  import ucode_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int UOP_CNT_W = UOP_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [ADDR_W-1:0]    instr_rom_addr,
  input  logic [UOP_CNT_W-1:0] instr_uop_cnt,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic                 instr_ack,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 uop_valid,
  output logic                 uop_first,
  output logic                 uop_last,
  output logic [UOP_CNT_W-1:0] uop_idx,
  output logic                 seq_busy
`ifdef UCODE_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_uop_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);
  seq_state_e state;
  logic [UOP_CNT_W-1:0] eff_cnt, eff_in, next_idx;
  logic adv, load, inc, in_single, seq_last;
  always_comb begin
    adv       = rst_n && !flush && !stall_in;
    load      = adv && state == IDLE && instr_valid;
    inc       = adv && state == SEQ;
    eff_in    = (instr_uop_cnt == '0) ? UOP_CNT_W'(UOP_CNT_MIN) : instr_uop_cnt;
    in_single = eff_in == UOP_CNT_W'(1);
    next_idx  = uop_idx + UOP_CNT_W'(1);
    seq_last  = next_idx == eff_cnt - UOP_CNT_W'(1);
    instr_ack = (load && in_single) || (inc && seq_last);
    seq_busy  = state == SEQ;
  end
  ucode_addr_ctr #(.ADDR_W(ADDR_W), .UOP_CNT_W(UOP_CNT_W)) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .inc       (inc),
    .load_addr (instr_rom_addr),
    .addr      (rom_addr),
    .idx       (uop_idx)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      eff_cnt   <= '0;
      uop_valid <= 1'b0;
      uop_first <= 1'b0;
      uop_last  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      uop_valid <= 1'b0;
      uop_first <= 1'b0;
      uop_last  <= 1'b0;
    end else if (!stall_in) begin
      if (state == IDLE) begin
        uop_valid <= instr_valid;
        uop_first <= instr_valid;
        uop_last  <= instr_valid && in_single;
        if (instr_valid) begin
          eff_cnt <= eff_in;
          state   <= in_single ? IDLE : SEQ;
        end
      end else begin
        uop_first <= 1'b0;
        uop_last  <= seq_last;
        state     <= seq_last ? IDLE : SEQ;
      end
    end
  end
`ifdef UCODE_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_uop_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if ((load || inc) && perf_uop_cnt != '1)
        perf_uop_cnt <= perf_uop_cnt + 32'd1;
      if (uop_valid && stall_in && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed plus random stimulus checked against a remaining-uop reference model
module tb_ucode_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, stall_in = 1'b0, flush = 1'b0;
  logic [7:0] instr_rom_addr = '0;
  logic [2:0] instr_uop_cnt = '0;
  logic instr_ack, uop_valid, uop_first, uop_last, seq_busy;
  logic [7:0] rom_addr;
  logic [2:0] uop_idx;
`ifdef UCODE_SEQ_PERF_EN
  logic [31:0] perf_uop_cnt, perf_stall_cnt;
`endif
  int errors = 0, checks = 0;
  int m_base, m_k, m_rem, e_addr, e_idx;
  logic e_valid, e_first, e_last;
  longint m_uops, m_stalls;
  always #5 clk = ~clk;
  ucode_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr_rom_addr (instr_rom_addr),
    .instr_uop_cnt  (instr_uop_cnt),
    .stall_in       (stall_in),
    .flush          (flush),
    .instr_ack      (instr_ack),
    .rom_addr       (rom_addr),
    .uop_valid      (uop_valid),
    .uop_first      (uop_first),
    .uop_last       (uop_last),
    .uop_idx        (uop_idx),
    .seq_busy       (seq_busy)
`ifdef UCODE_SEQ_PERF_EN
    ,
    .perf_uop_cnt   (perf_uop_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_out();
    chk("rom_addr", 32'(rom_addr), 32'(e_addr));
    chk("uop_idx", 32'(uop_idx), 32'(e_idx));
    chk("uop_valid", 32'(uop_valid), 32'(e_valid));
    chk("uop_first", 32'(uop_first), 32'(e_first));
    chk("uop_last", 32'(uop_last), 32'(e_last));
    chk("seq_busy", 32'(seq_busy), 32'(m_rem > 0));
`ifdef UCODE_SEQ_PERF_EN
    chk("perf_uop", perf_uop_cnt, 32'(m_uops));
    chk("perf_stall", perf_stall_cnt, 32'(m_stalls));
`endif
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_ack", 32'(instr_ack), 32'd0);
    @(posedge clk);
    #1;
    m_base = 0; m_k = 0; m_rem = 0; e_addr = 0; e_idx = 0;
    e_valid = 0; e_first = 0; e_last = 0; m_uops = 0; m_stalls = 0;
    chk_out();
    rst_n = 1'b1;
  endtask
  task automatic step(input logic v, input logic [7:0] a, input logic [2:0] c, input logic st, input logic fl);
    int n;
    logic exp_ack;
    instr_valid = v;
    instr_rom_addr = a;
    instr_uop_cnt = c;
    stall_in = st;
    flush = fl;
    #1;
    n = (c == 0) ? 1 : int'(c);
    exp_ack = !fl && !st && ((m_rem > 0) ? (m_rem == 1) : (v && n == 1));
    chk("instr_ack", 32'(instr_ack), 32'(exp_ack));
    chk("busy_pre", 32'(seq_busy), 32'(m_rem > 0));
    if (e_valid && st && m_stalls != 64'hFFFF_FFFF) m_stalls++;
    if (!fl && !st && (m_rem > 0 || v) && m_uops != 64'hFFFF_FFFF) m_uops++;
    if (fl) begin
      e_valid = 0; e_first = 0; e_last = 0; m_rem = 0;
    end else if (!st) begin
      if (m_rem > 0) begin
        m_k++; m_rem--;
        e_addr = (m_base + m_k) % 256; e_idx = m_k;
        e_first = 0; e_last = (m_rem == 0);
      end else if (v) begin
        m_base = int'(a); m_k = 0; m_rem = n - 1;
        e_addr = int'(a); e_idx = 0;
        e_valid = 1; e_first = 1; e_last = (n == 1);
      end else begin
        e_valid = 0; e_first = 0; e_last = 0;
      end
    end
    @(posedge clk);
    #1;
    chk_out();
  endtask
  initial begin
    do_reset();
    step(1, 8'h40, 3'd1, 0, 0);
    chk("single_addr", 32'(rom_addr), 32'h40);
    chk("single_last", 32'(uop_last), 32'd1);
    step(1, 8'h10, 3'd3, 0, 0);
    step(0, 8'h00, 3'd0, 0, 0);
    step(0, 8'h00, 3'd0, 0, 0);
    chk("three_last_addr", 32'(rom_addr), 32'h12);
    step(1, 8'h10, 3'd3, 0, 0);
    step(0, 8'h00, 3'd0, 0, 0);
    step(0, 8'h00, 3'd0, 1, 0);
    step(0, 8'h00, 3'd0, 1, 0);
    chk("stall_hold_addr", 32'(rom_addr), 32'h11);
    chk("stall_hold_idx", 32'(uop_idx), 32'd1);
    step(0, 8'h00, 3'd0, 0, 0);
    step(1, 8'hFE, 3'd4, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 3'd0, 0, 0);
    chk("wrap_addr", 32'(rom_addr), 32'h01);
    chk("wrap_last", 32'(uop_last), 32'd1);
    step(1, 8'h20, 3'd4, 0, 0);
    step(0, 8'h00, 3'd0, 0, 0);
    step(1, 8'h55, 3'd2, 1, 1);
    chk("flush_valid", 32'(uop_valid), 32'd0);
    step(1, 8'h80, 3'd1, 0, 0);
    chk("post_flush_addr", 32'(rom_addr), 32'h80);
    step(0, 8'h00, 3'd0, 0, 0);
    do_reset();
    step(1, 8'h50, 3'd0, 0, 0);
    chk("cnt0_last", 32'(uop_last), 32'd1);
    step(1, 8'h60, 3'd4, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 3'd0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 3'd0, 0, 0);
    step(0, 8'h00, 3'd0, 0, 0);
`ifdef UCODE_SEQ_PERF_EN
    chk("perf_uop5", perf_uop_cnt, 32'd5);
    chk("perf_stall3", perf_stall_cnt, 32'd3);
`endif
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
